// File: rtl/sram_controller.sv
// sram_controller
// Bridges a 32-bit load/store request from the memory stage onto a 16-bit
// asynchronous SRAM. Each word access is split into a low and a high
// half-word access, and each half is held for WAIT_CYCLES extra cycles.
//
// Parameters
//   WAIT_CYCLES : extra hold cycles per half-access (0..7)
//   BASE_ADDR   : byte address that maps to SRAM word 0
// Ports
//   clk, rst          : clock and asynchronous active-high reset
//   wr_en, rd_en      : store / load request (store wins if both are set)
//   address           : byte address of the access
//   write_data        : store data
//   read_data         : assembled load data, held until the next load
//   ready             : 0 stalls the pipeline, 1 lets the memory stage advance
//   SRAM_DQ           : bidirectional SRAM data bus
//   SRAM_ADDR         : SRAM half-word address
//   SRAM_*_N          : active-low SRAM strobes
module sram_controller #(
    parameter int WAIT_CYCLES = 1,
    parameter int BASE_ADDR   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [2:0]  WAIT_C = WAIT_CYCLES[2:0];
    localparam logic [31:0] BASE_C = BASE_ADDR;

    state_t      state_q, state_d;
    logic [2:0]  count_q, count_d;
    logic        op_write_q, op_write_d;
    logic [31:0] read_data_q, read_data_d;
    logic        we_n_q, we_n_d;
    logic        oe_n_q, oe_n_d;
    logic        ce_n_q, ce_n_d;

    logic [31:0] addr_off;
    logic [16:0] word_index;
    logic        in_acc_d;
    logic        dq_drive;
    logic [15:0] dq_out;
    logic        unused_addr_bits;

    // The address is not latched: the requester holds it stable while
    // ready is low, so the SRAM address is decoded straight from it.
    assign addr_off         = address - BASE_C;
    assign word_index       = addr_off[18:2];
    assign unused_addr_bits = ^{addr_off[31:19], addr_off[1:0]};

    // Next-state logic. The strobes are computed from the next state so
    // that they come out of flops rather than from decode of state_q.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        op_write_d  = op_write_q;
        read_data_d = read_data_q;
        case (state_q)
            IDLE: begin
                if (wr_en || rd_en) begin
                    state_d    = ACC_LO;
                    count_d    = 3'd0;
                    op_write_d = wr_en;
                end
            end
            ACC_LO: begin
                if (count_q == WAIT_C) begin
                    state_d = ACC_HI;
                    count_d = 3'd0;
                    if (!op_write_q) begin
                        read_data_d[15:0] = SRAM_DQ;
                    end
                end else begin
                    count_d = count_q + 3'd1;
                end
            end
            ACC_HI: begin
                if (count_q == WAIT_C) begin
                    state_d = DONE;
                    count_d = 3'd0;
                    if (!op_write_q) begin
                        read_data_d[31:16] = SRAM_DQ;
                    end
                end else begin
                    count_d = count_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                count_d = 3'd0;
            end
            default: begin
                state_d = IDLE;
                count_d = 3'd0;
            end
        endcase

        in_acc_d = (state_d == ACC_LO) || (state_d == ACC_HI);
        ce_n_d   = !in_acc_d;
        we_n_d   = !(in_acc_d && op_write_d);
        oe_n_d   = !(in_acc_d && !op_write_d);
    end

    // Single state register; reset abandons any access in flight and
    // discards a partially assembled load word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= 3'd0;
            op_write_q  <= 1'b0;
            read_data_q <= 32'd0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            ce_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            op_write_q  <= op_write_d;
            read_data_q <= read_data_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            ce_n_q      <= ce_n_d;
        end
    end

    // Output decode: ready in IDLE is combinational so an idle controller
    // never stalls a stage that has no memory operation.
    always_comb begin
        SRAM_ADDR = 18'd0;
        dq_drive  = 1'b0;
        dq_out    = 16'd0;
        ready     = 1'b0;
        case (state_q)
            IDLE: ready = !(wr_en || rd_en);
            ACC_LO: begin
                SRAM_ADDR = {word_index, 1'b0};
                dq_drive  = op_write_q;
                dq_out    = write_data[15:0];
            end
            ACC_HI: begin
                SRAM_ADDR = {word_index, 1'b1};
                dq_drive  = op_write_q;
                dq_out    = write_data[31:16];
            end
            DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign SRAM_DQ   = dq_drive ? dq_out : 16'bz;
    assign read_data = read_data_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_UB_N = ce_n_q;
    assign SRAM_LB_N = ce_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller
// Drives two controllers (WAIT_CYCLES=1 and WAIT_CYCLES=0) from a shared
// requester, with a half-word SRAM model on each bus and a word-level
// reference memory that predicts every bus phase and load result.
module tb_sram_controller;

    localparam logic [15:0] PROBE = 16'h8001;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        wr_req, rd_req;
    logic [31:0] address, write_data;

    logic        wr_a, rd_a, wr_b, rd_b;
    logic [31:0] rdata_a, rdata_b;
    logic        ready_a, ready_b;
    wire  [15:0] dq_a, dq_b;
    logic [17:0] addr_a, addr_b;
    logic        we_a, oe_a, ce_a, ub_a, lb_a;
    logic        we_b, oe_b, ce_b, ub_b, lb_b;

    logic [15:0] mem_a [1024];
    logic [15:0] mem_b [1024];
    logic [31:0] ref_mem [2][256];
    logic [31:0] rd_model [2];

    logic [31:0] o_rd;
    logic        o_ready, o_we, o_oe, o_ce, o_ub, o_lb;
    logic [15:0] o_dq;
    logic [17:0] o_addr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Only the selected controller sees the request.
    assign wr_a = !sel && wr_req;
    assign rd_a = !sel && rd_req;
    assign wr_b = sel && wr_req;
    assign rd_b = sel && rd_req;

    sram_controller #(.WAIT_CYCLES(1), .BASE_ADDR(1024)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_a), .rd_en(rd_a),
        .address(address), .write_data(write_data),
        .read_data(rdata_a), .ready(ready_a), .SRAM_DQ(dq_a),
        .SRAM_ADDR(addr_a), .SRAM_WE_N(we_a), .SRAM_OE_N(oe_a),
        .SRAM_CE_N(ce_a), .SRAM_UB_N(ub_a), .SRAM_LB_N(lb_a)
    );

    sram_controller #(.WAIT_CYCLES(0), .BASE_ADDR(1024)) dut_w0 (
        .clk(clk), .rst(rst), .wr_en(wr_b), .rd_en(rd_b),
        .address(address), .write_data(write_data),
        .read_data(rdata_b), .ready(ready_b), .SRAM_DQ(dq_b),
        .SRAM_ADDR(addr_b), .SRAM_WE_N(we_b), .SRAM_OE_N(oe_b),
        .SRAM_CE_N(ce_b), .SRAM_UB_N(ub_b), .SRAM_LB_N(lb_b)
    );

    // SRAM models: drive read data when enabled for output, otherwise a
    // probe pattern whenever the bus should be released by the controller.
    assign dq_a = (!oe_a && !ce_a) ? mem_a[addr_a[9:0]] : (we_a ? PROBE : 16'bz);
    assign dq_b = (!oe_b && !ce_b) ? mem_b[addr_b[9:0]] : (we_b ? PROBE : 16'bz);

    always @(posedge clk) begin
        if (!we_a && !ce_a) mem_a[addr_a[9:0]] <= dq_a;
        if (!we_b && !ce_b) mem_b[addr_b[9:0]] <= dq_b;
    end

    assign o_rd    = sel ? rdata_b : rdata_a;
    assign o_ready = sel ? ready_b : ready_a;
    assign o_dq    = sel ? dq_b : dq_a;
    assign o_addr  = sel ? addr_b : addr_a;
    assign o_we    = sel ? we_b : we_a;
    assign o_oe    = sel ? oe_b : oe_a;
    assign o_ce    = sel ? ce_b : ce_a;
    assign o_ub    = sel ? ub_b : ub_a;
    assign o_lb    = sel ? lb_b : lb_a;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic checkIdleBus(input string tag);
        checkOutput({tag, "_ctrl"}, 32'({o_we, o_oe, o_ce, o_ub, o_lb}), 32'h1f);
        checkOutput({tag, "_dq"}, 32'(o_dq), 32'(PROBE));
    endtask

    task automatic idleCycles(input int n);
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("idle_ready", 32'(o_ready), 32'd1);
            checkIdleBus("idle");
            if (i < n - 1) @(posedge clk);
        end
    endtask

    // One complete access, cycle 1 being the first IDLE cycle in which the
    // request is visible. Expected behaviour comes from the word-level
    // reference memory and the latency formula 2*(W+1)+2.
    task automatic applyStimulus(input logic s, input logic w, input logic r,
                                 input int idx, input logic [1:0] lo, input logic [31:0] d);
        int          wc;
        int          lat;
        logic        hi;
        logic [31:0] word;
        logic [16:0] ix;
        @(posedge clk);
        #1;
        sel        = s;
        wr_req     = w;
        rd_req     = r;
        address    = 32'(1024 + 4 * idx) | {30'd0, lo};
        write_data = d;
        wc   = s ? 0 : 1;
        lat  = 2 * (wc + 1) + 2;
        word = ref_mem[s][idx];
        ix   = 17'(idx);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checkOutput("req_ready", 32'(o_ready), 32'd0);
                checkIdleBus("req");
            end else if (c < lat) begin
                hi = (c - 2) >= (wc + 1);
                checkOutput("acc_ready", 32'(o_ready), 32'd0);
                checkOutput("acc_ce", 32'({o_ce, o_ub, o_lb}), 32'd0);
                checkOutput("acc_addr", 32'(o_addr), 32'({ix, hi}));
                if (w) begin
                    checkOutput("wr_strobes", 32'({o_we, o_oe}), 32'b01);
                    checkOutput("wr_dq", 32'(o_dq), 32'(hi ? d[31:16] : d[15:0]));
                end else begin
                    checkOutput("rd_strobes", 32'({o_we, o_oe}), 32'b10);
                    checkOutput("rd_dq", 32'(o_dq), 32'(hi ? word[31:16] : word[15:0]));
                end
            end else begin
                if (w) ref_mem[s][idx] = d;
                else rd_model[s] = word;
                checkOutput("done_ready", 32'(o_ready), 32'd1);
                checkIdleBus("done");
                checkOutput("read_data", o_rd, rd_model[s]);
                checkOutput("mem_word",
                            s ? {mem_b[2*idx+1], mem_b[2*idx]} : {mem_a[2*idx+1], mem_a[2*idx]},
                            ref_mem[s][idx]);
            end
            if (c < lat) @(posedge clk);
        end
    endtask

    // Abandon a read on the WAIT_CYCLES=1 controller while it is in its
    // high half-access, after the low half has already been captured.
    task automatic resetMidRead(input int idx);
        @(posedge clk);
        #1;
        sel     = 1'b0;
        wr_req  = 1'b0;
        rd_req  = 1'b1;
        address = 32'(1024 + 4 * idx);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("pre_rst_addr", 32'(o_addr), 32'({17'(idx), 1'b1}));
        rst = 1'b1;
        #1;
        rd_model[0] = 32'd0;
        checkOutput("rst_read_data", o_rd, 32'd0);
        checkOutput("rst_addr", 32'(o_addr), 32'd0);
        checkIdleBus("rst");
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("post_rst_ready", 32'(o_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        int          op;
        rst        = 1'b1;
        sel        = 1'b0;
        wr_req     = 1'b0;
        rd_req     = 1'b0;
        address    = 32'd0;
        write_data = 32'd0;
        rd_model[0] = 32'd0;
        rd_model[1] = 32'd0;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 16'd0;
            mem_b[i] = 16'd0;
        end
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            ref_mem[0][i] = v;
            ref_mem[1][i] = v;
            mem_a[2*i]   = v[15:0];
            mem_a[2*i+1] = v[31:16];
            mem_b[2*i]   = v[15:0];
            mem_b[2*i+1] = v[31:16];
        end

        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            checkOutput("reset_read_data", o_rd, 32'd0);
            checkOutput("reset_addr", 32'(o_addr), 32'd0);
            checkIdleBus("reset");
        end
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Directed word store and load at byte address 1028.
        applyStimulus(1'b0, 1'b1, 1'b0, 1, 2'd0, 32'hDEADBEEF);
        idleCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1, 2'd0, 32'h12345678);
        idleCycles(1);

        // Simultaneous store and load: the store wins.
        applyStimulus(1'b0, 1'b1, 1'b1, 5, 2'd2, 32'hCAFEF00D);

        // Back-to-back on the zero-wait controller, low address bits ignored.
        applyStimulus(1'b1, 1'b1, 1'b0, 7, 2'd0, 32'hA5A55A5A);
        applyStimulus(1'b1, 1'b0, 1'b1, 7, 2'd3, 32'h0F0F0F0F);
        applyStimulus(1'b1, 1'b0, 1'b1, 9, 2'd1, 32'h00000000);

        resetMidRead(3);
        applyStimulus(1'b0, 1'b0, 1'b1, 3, 2'd0, 32'h11111111);

        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 2));
            applyStimulus(1'($urandom_range(0, 1)), op != 1, op != 0,
                          int'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), $urandom);
            if ($urandom_range(0, 1) == 1) idleCycles(int'($urandom_range(1, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
